// File: rtl/xgmii_tx_scheduler.sv
// Four-requester round-robin scheduler feeding one XGMII TX interface.
// Inserts an idle gap after every frame and aborts frames that run past MAX_BEATS beats.
module xgmii_tx_scheduler #(
  parameter int unsigned IFG_CYCLES = 2,
  parameter int unsigned MAX_BEATS  = 200
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic [3:0]   req,
  input  logic [3:0]   last,
  input  logic [255:0] txd_in,
  input  logic [31:0]  txc_in,
  output logic [3:0]   grant,
  output logic [63:0]  xgmii_txd,
  output logic [7:0]   xgmii_txc,
  output logic         busy,
  output logic [31:0]  frame_cnt,
  output logic [15:0]  abort_cnt
);

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned IFG_W  = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  localparam logic [63:0] IDLE_TXD  = 64'h0707070707070707;
  localparam logic [63:0] ABORT_TXD = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [7:0]  CTRL_ALL  = 8'hFF;
  localparam logic [15:0] ABORT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_XMIT, ST_ABORT, ST_IFG} state_e;

  // With no gap configured a finished frame goes straight back to arbitration.
  localparam state_e POST_FRAME = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [IFG_W-1:0]   ifg_q, ifg_d;
  logic [3:0]         grant_q, grant_d;
  logic [63:0]        txd_q, txd_d;
  logic [7:0]         txc_q, txc_d;
  logic               busy_q, busy_d;
  logic [31:0]        frame_cnt_q, frame_cnt_d;
  logic [15:0]        abort_cnt_q, abort_cnt_d;

  logic [SEL_W-1:0]   win;
  logic [SEL_W-1:0]   idx;
  logic               found;
  logic [63:0]        beat_txd;
  logic [7:0]         beat_txc;
  logic               last_g;

  assign beat_txd = txd_in[{sel_q, 6'd0} +: 64];
  assign beat_txc = txc_in[{sel_q, 3'd0} +: 8];
  assign last_g   = last[sel_q];

  // Round-robin search starting at rr_ptr_q, ascending modulo four.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = rr_ptr_q + SEL_W'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    ifg_d       = ifg_q;
    grant_d     = grant_q;
    txd_d       = IDLE_TXD;
    txc_d       = CTRL_ALL;
    frame_cnt_d = frame_cnt_q;
    abort_cnt_d = abort_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d  = ST_XMIT;
          sel_d    = win;
          grant_d  = 4'(1) << win;
          rr_ptr_d = win + SEL_W'(1);
          beat_d   = '0;
        end
      end
      ST_XMIT: begin
        // last wins over the beat limit, so a frame ending on the limit is not aborted.
        if (last_g) begin
          txd_d       = beat_txd;
          txc_d       = beat_txc;
          grant_d     = '0;
          frame_cnt_d = frame_cnt_q + 32'd1;
          ifg_d       = IFG_W'(IFG_CYCLES);
          state_d     = POST_FRAME;
        end else if (beat_q == BEAT_W'(MAX_BEATS - 1)) begin
          txd_d   = ABORT_TXD;
          txc_d   = CTRL_ALL;
          grant_d = '0;
          state_d = ST_ABORT;
          if (abort_cnt_q != ABORT_MAX) begin
            abort_cnt_d = abort_cnt_q + 16'd1;
          end
        end else begin
          txd_d  = beat_txd;
          txc_d  = beat_txc;
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_ABORT: begin
        ifg_d   = IFG_W'(IFG_CYCLES);
        state_d = POST_FRAME;
      end
      ST_IFG: begin
        if (ifg_q <= IFG_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          ifg_d = ifg_q - IFG_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      beat_q      <= '0;
      ifg_q       <= '0;
      grant_q     <= '0;
      txd_q       <= IDLE_TXD;
      txc_q       <= CTRL_ALL;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_q      <= beat_d;
      ifg_q       <= ifg_d;
      grant_q     <= grant_d;
      txd_q       <= txd_d;
      txc_q       <= txc_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign xgmii_txd = txd_q;
  assign xgmii_txc = txc_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Directed bench for xgmii_tx_scheduler: inputs change and outputs are sampled on the falling edge.
module tb_xgmii_tx_scheduler;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [63:0] ABORT_D = 64'hFEFEFEFEFEFEFEFE;

  logic         sys_clk;
  logic         sys_rst;
  logic [3:0]   req;
  logic [3:0]   last;
  logic [255:0] txd_in;
  logic [31:0]  txc_in;
  logic [3:0]   grant;
  logic [63:0]  xgmii_txd;
  logic [7:0]   xgmii_txc;
  logic         busy;
  logic [31:0]  frame_cnt;
  logic [15:0]  abort_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  xgmii_tx_scheduler #(.IFG_CYCLES(2), .MAX_BEATS(200)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .last      (last),
    .txd_in    (txd_in),
    .txc_in    (txc_in),
    .grant     (grant),
    .xgmii_txd (xgmii_txd),
    .xgmii_txc (xgmii_txc),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .abort_cnt (abort_cnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic set_lane(input int i, input logic [63:0] d);
    txd_in[64*i +: 64] = d;
  endtask

  function automatic logic [63:0] pat(input int lane, input int k);
    return {16'hDA7A, 8'(lane), 8'h00, 32'(k)};
  endfunction

  initial begin
    sys_rst = 1'b0;
    req     = '0;
    last    = '0;
    txd_in  = '0;
    txc_in  = '0;

    // Reset state
    #12;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_txd", xgmii_txd, IDLE_D);
    chk("rst_txc", 64'(xgmii_txc), 64'hFF);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_frame", 64'(frame_cnt), 64'h0);
    chk("rst_abort", 64'(abort_cnt), 64'h0);
    tick();
    sys_rst = 1'b1;
    tick();

    // Three-beat frame on requester 0
    req = 4'b0001;
    tick();
    chk("f3_grant0", 64'(grant), 64'h1);
    chk("f3_busy", 64'(busy), 64'h1);
    chk("f3_txd_pre", xgmii_txd, IDLE_D);
    set_lane(0, 64'hD0D0_0000_0000_0000);
    tick();
    chk("f3_txd_d0", xgmii_txd, 64'hD0D0_0000_0000_0000);
    chk("f3_txc_d0", 64'(xgmii_txc), 64'h0);
    chk("f3_grant1", 64'(grant), 64'h1);
    set_lane(0, 64'hD1D1_0000_0000_0001);
    tick();
    chk("f3_txd_d1", xgmii_txd, 64'hD1D1_0000_0000_0001);
    set_lane(0, 64'hD2D2_0000_0000_0002);
    last = 4'b0001;
    tick();
    chk("f3_txd_d2", xgmii_txd, 64'hD2D2_0000_0000_0002);
    chk("f3_grant_off", 64'(grant), 64'h0);
    chk("f3_frame", 64'(frame_cnt), 64'h1);
    chk("f3_busy_ifg", 64'(busy), 64'h1);
    req  = '0;
    last = '0;
    tick();
    chk("f3_ifg_txd", xgmii_txd, IDLE_D);
    chk("f3_ifg_txc", 64'(xgmii_txc), 64'hFF);
    chk("f3_ifg_busy", 64'(busy), 64'h1);
    tick();
    chk("f3_idle_busy", 64'(busy), 64'h0);
    chk("f3_idle_txd", xgmii_txd, IDLE_D);

    // Short reset pulse between edges so round-robin starts at 0 again
    #2 sys_rst = 1'b0;
    #2 sys_rst = 1'b1;
    tick();
    chk("rst2_frame", 64'(frame_cnt), 64'h0);

    // All requesters ready, single-beat frames: 0,1,2,3,0 with three empty cycles between
    req  = 4'b1111;
    last = 4'b1111;
    for (int c = 1; c <= 17; c++) begin
      logic [3:0] exp_g;
      tick();
      exp_g = ((c - 1) % 4 == 0) ? 4'(4'd1 << (((c - 1) / 4) % 4)) : 4'd0;
      chk("rr_grant", 64'(grant), 64'(exp_g));
    end
    tick();
    chk("rr_frames", 64'(frame_cnt), 64'h5);
    req  = '0;
    last = '0;
    tick();
    tick();
    chk("rr_idle", 64'(busy), 64'h0);

    // Foreign last and dropped req do not disturb the granted frame
    req = 4'b0001;
    tick();
    chk("hold_grant_a", 64'(grant), 64'h1);
    req  = '0;
    last = 4'b0010;
    set_lane(0, 64'hA0A0_0000_0000_0000);
    tick();
    chk("hold_grant_b", 64'(grant), 64'h1);
    chk("hold_txd_a0", xgmii_txd, 64'hA0A0_0000_0000_0000);
    set_lane(0, 64'hA1A1_0000_0000_0001);
    tick();
    chk("hold_grant_c", 64'(grant), 64'h1);
    chk("hold_txd_a1", xgmii_txd, 64'hA1A1_0000_0000_0001);
    last = 4'b0001;
    set_lane(0, 64'hA2A2_0000_0000_0002);
    tick();
    chk("hold_grant_off", 64'(grant), 64'h0);
    chk("hold_txd_a2", xgmii_txd, 64'hA2A2_0000_0000_0002);
    chk("hold_frame", 64'(frame_cnt), 64'h6);
    last = '0;
    tick();
    tick();
    chk("hold_idle", 64'(busy), 64'h0);

    // Requester 2 never ends its frame: 199 beats then one abort cycle
    req = 4'b0100;
    tick();
    chk("wd_grant", 64'(grant), 64'h4);
    req = '0;
    for (int k = 0; k < 200; k++) begin
      set_lane(2, pat(2, k));
      tick();
      if (k < 199) begin
        chk("wd_beat", xgmii_txd, pat(2, k));
        if (k == 0 || k == 198) chk("wd_grant_on", 64'(grant), 64'h4);
      end else begin
        chk("wd_abort_txd", xgmii_txd, ABORT_D);
        chk("wd_abort_txc", 64'(xgmii_txc), 64'hFF);
        chk("wd_grant_off", 64'(grant), 64'h0);
        chk("wd_abort_cnt", 64'(abort_cnt), 64'h1);
        chk("wd_frame_cnt", 64'(frame_cnt), 64'h6);
        chk("wd_busy", 64'(busy), 64'h1);
      end
    end
    tick();
    chk("wd_ifg_txd", xgmii_txd, IDLE_D);
    tick();
    tick();
    chk("wd_idle", 64'(busy), 64'h0);

    // Reset in the middle of a frame on requester 1
    req = 4'b0010;
    tick();
    chk("mr_grant", 64'(grant), 64'h2);
    for (int k = 0; k < 5; k++) begin
      set_lane(1, pat(1, k));
      tick();
      chk("mr_beat", xgmii_txd, pat(1, k));
    end
    set_lane(1, pat(1, 5));
    #2 sys_rst = 1'b0;
    #1;
    chk("mr_txd", xgmii_txd, IDLE_D);
    chk("mr_txc", 64'(xgmii_txc), 64'hFF);
    chk("mr_grant_off", 64'(grant), 64'h0);
    chk("mr_busy", 64'(busy), 64'h0);
    chk("mr_frame", 64'(frame_cnt), 64'h0);
    chk("mr_abort", 64'(abort_cnt), 64'h0);
    tick();
    sys_rst = 1'b1;
    req     = 4'b1001;
    tick();
    chk("mr_regrant0", 64'(grant), 64'h1);
    last = 4'b0001;
    tick();
    chk("mr_end0", 64'(grant), 64'h0);
    chk("mr_frame1", 64'(frame_cnt), 64'h1);
    last = '0;
    req  = 4'b1000;
    tick();
    tick();
    tick();
    chk("mr_regrant3", 64'(grant), 64'h8);
    last = 4'b1000;
    tick();
    chk("mr_frame2", 64'(frame_cnt), 64'h2);
    last = '0;
    req  = '0;
    tick();
    tick();
    chk("mr_idle", 64'(busy), 64'h0);

    // Counter wrap and saturation
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    force dut.abort_cnt_q = 16'hFFFF;
    tick();
    release dut.frame_cnt_q;
    release dut.abort_cnt_q;
    tick();
    chk("sat_frame_pre", 64'(frame_cnt), 64'hFFFF_FFFF);
    chk("sat_abort_pre", 64'(abort_cnt), 64'hFFFF);
    req = 4'b0001;
    tick();
    chk("sat_grant", 64'(grant), 64'h1);
    last = 4'b0001;
    tick();
    chk("sat_frame_wrap", 64'(frame_cnt), 64'h0);
    last = '0;
    tick();
    tick();
    tick();
    chk("sat_grant2", 64'(grant), 64'h1);
    req = '0;
    for (int k = 0; k < 200; k++) begin
      set_lane(0, pat(0, k));
      tick();
    end
    chk("sat_abort_txd", xgmii_txd, ABORT_D);
    chk("sat_abort_cnt", 64'(abort_cnt), 64'hFFFF);
    chk("sat_frame_keep", 64'(frame_cnt), 64'h0);
    tick();
    tick();
    tick();
    chk("sat_idle", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
